// File: rtl/sha256_msg_loader.sv
// rtl/sha256_msg_loader.sv - SHA-256 single-block padder/loader and digest reader for sha256_core
// Optional watchdog on the core interrupt: define SHA_LOADER_TIMEOUT_EN.
module sha256_msg_loader #(
  parameter int MAX_LEN     = 55,
  parameter int STATUS_ADDR = 81,
  parameter int DIGEST_TOP  = 117,
  parameter int WORD_TOP    = 63
`ifdef SHA_LOADER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_s_data,
  input  logic       i_s_valid,
  input  logic       i_s_last,
  output logic       o_s_ready,
  output logic [7:0] o_m_data,
  output logic       o_m_valid,
  output logic       o_m_last,
  input  logic       i_m_ready,
  output logic [6:0] o_w_addr,
  output logic [7:0] o_data8,
  output logic       o_we,
  input  logic [7:0] i_core_data,
  input  logic       i_core_irq,
  output logic       o_busy,
  output logic       o_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_PAD   = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_READ  = 3'd5;
  localparam logic [2:0] S_DRAIN = 3'd6;

  localparam logic [6:0] WORD_A   = 7'(WORD_TOP);
  localparam logic [6:0] DIGEST_A = 7'(DIGEST_TOP);
  localparam logic [6:0] STATUS_A = 7'(STATUS_ADDR);
  localparam logic [5:0] MAX_K    = 6'(MAX_LEN);

  logic [2:0] state_q, state_d;
  logic [5:0] k_q, k_d;
  logic [5:0] len_q, len_d;
  logic [4:0] j_q, j_d;
  logic       we_q, we_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       err_q, err_d;
  logic       start_ph_q, start_ph_d;
  logic       alive_q;
`ifdef SHA_LOADER_TIMEOUT_EN
  logic [7:0] wd_q, wd_d;
`endif

  logic       accept;
  logic [8:0] bit_len;
  logic [7:0] pad_byte;

  // alive_q keeps o_s_ready low while reset is held and for the first edge after release
  assign o_s_ready = alive_q && (state_q == S_IDLE || state_q == S_LOAD || state_q == S_DRAIN);
  assign accept    = i_s_valid && o_s_ready;
  assign bit_len   = {len_q, 3'b000};

  always_comb begin
    pad_byte = 8'h00;
    if (k_q == len_q)       pad_byte = 8'h80;
    else if (k_q == 6'd62)  pad_byte = {7'd0, bit_len[8]};
    else if (k_q == 6'd63)  pad_byte = bit_len[7:0];
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    len_d      = len_q;
    j_d        = j_q;
    we_d       = 1'b0;
    addr_d     = 7'd0;
    data_d     = 8'd0;
    err_d      = err_q;
    start_ph_d = start_ph_q;
`ifdef SHA_LOADER_TIMEOUT_EN
    wd_d       = wd_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          err_d  = 1'b0;
          we_d   = 1'b1;
          addr_d = WORD_A;
          data_d = i_s_data;
          k_d    = 6'd1;
          if (i_s_last) begin
            len_d   = 6'd1;
            state_d = S_PAD;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (k_q == MAX_K) begin
            err_d   = 1'b1;
            k_d     = 6'd0;
            state_d = i_s_last ? S_IDLE : S_DRAIN;
          end else begin
            we_d   = 1'b1;
            addr_d = WORD_A - {1'b0, k_q};
            data_d = i_s_data;
            k_d    = k_q + 6'd1;
            if (i_s_last) begin
              len_d   = k_q + 6'd1;
              state_d = S_PAD;
            end
          end
        end
      end
      S_PAD: begin
        we_d   = 1'b1;
        addr_d = WORD_A - {1'b0, k_q};
        data_d = pad_byte;
        if (k_q == 6'd63) begin
          k_d        = 6'd0;
          start_ph_d = 1'b0;
          state_d    = S_START;
        end else begin
          k_d = k_q + 6'd1;
        end
      end
      S_START: begin
        // Phase 0 registers the START write; phase 1 lets it drive the bus before WAIT
        if (!start_ph_q) begin
          we_d       = 1'b1;
          addr_d     = STATUS_A;
          data_d     = 8'h01;
          start_ph_d = 1'b1;
        end else begin
          start_ph_d = 1'b0;
          state_d    = S_WAIT;
`ifdef SHA_LOADER_TIMEOUT_EN
          wd_d       = 8'd0;
`endif
        end
      end
      S_WAIT: begin
        if (i_core_irq) begin
          j_d     = 5'd0;
          state_d = S_READ;
        end
`ifdef SHA_LOADER_TIMEOUT_EN
        else if (wd_q == 8'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 8'd1;
        end
`endif
      end
      S_READ: begin
        if (i_m_ready) begin
          if (j_q == 5'd31) begin
            j_d     = 5'd0;
            state_d = S_IDLE;
          end else begin
            j_d = j_q + 5'd1;
          end
        end
      end
      S_DRAIN: begin
        if (accept && i_s_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      k_q        <= 6'd0;
      len_q      <= 6'd0;
      j_q        <= 5'd0;
      we_q       <= 1'b0;
      addr_q     <= 7'd0;
      data_q     <= 8'd0;
      err_q      <= 1'b0;
      start_ph_q <= 1'b0;
      alive_q    <= 1'b0;
`ifdef SHA_LOADER_TIMEOUT_EN
      wd_q       <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      len_q      <= len_d;
      j_q        <= j_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      err_q      <= err_d;
      start_ph_q <= start_ph_d;
      alive_q    <= 1'b1;
`ifdef SHA_LOADER_TIMEOUT_EN
      wd_q       <= wd_d;
`endif
    end
  end

  assign o_we      = we_q;
  assign o_data8   = data_q;
  assign o_w_addr  = (state_q == S_READ) ? (DIGEST_A - {2'b00, j_q}) : addr_q;
  assign o_m_valid = (state_q == S_READ);
  assign o_m_data  = o_m_valid ? i_core_data : 8'h00;
  assign o_m_last  = o_m_valid && (j_q == 5'd31);
  assign o_busy    = (state_q != S_IDLE);
  assign o_err     = err_q;

endmodule

// File: tb/tb_sha256_msg_loader.sv
// tb/tb_sha256_msg_loader.sv - randomized scoreboard bench for sha256_msg_loader with a behavioural sha256_core
module tb_sha256_msg_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_data;
  logic       s_valid, s_last, s_ready;
  logic [7:0] m_data;
  logic       m_valid, m_last, m_ready;
  logic [6:0] w_addr;
  logic [7:0] data8;
  logic       we;
  logic [7:0] core_data;
  logic       core_irq;
  logic       busy, err;

  always #5 clk = ~clk;

  sha256_msg_loader dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_s_data(s_data), .i_s_valid(s_valid), .i_s_last(s_last), .o_s_ready(s_ready),
    .o_m_data(m_data), .o_m_valid(m_valid), .o_m_last(m_last), .i_m_ready(m_ready),
    .o_w_addr(w_addr), .o_data8(data8), .o_we(we),
    .i_core_data(core_data), .i_core_irq(core_irq),
    .o_busy(busy), .o_err(err)
  );

  typedef struct { logic [6:0] addr; logic [7:0] data; int tag; int len; } wr_t;
  typedef struct { logic [7:0] data; logic last; logic [6:0] addr; } dg_t;

  wr_t wq[$];
  dg_t dq[$];
  int  checks = 0;
  int  errors = 0;
  int  rdy_mode = 2;

  localparam logic [31:0] KC [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha256_blk(input logic [7:0] b[64]);
    logic [31:0] w[64];
    logic [31:0] a, bb, c, d, e, f, g, h, t1, t2;
    logic [31:0] h0 [8];
    h0 = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int t = 0; t < 16; t++) w[t] = {b[4*t], b[4*t+1], b[4*t+2], b[4*t+3]};
    for (int t = 16; t < 64; t++)
      w[t] = w[t-16] + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-7]
           + (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10));
    a = h0[0]; bb = h0[1]; c = h0[2]; d = h0[3]; e = h0[4]; f = h0[5]; g = h0[6]; h = h0[7];
    for (int t = 0; t < 64; t++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + KC[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & bb) ^ (a & c) ^ (bb & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = bb; bb = a; a = t1 + t2;
    end
    return {h0[0] + a, h0[1] + bb, h0[2] + c, h0[3] + d, h0[4] + e, h0[5] + f, h0[6] + g, h0[7] + h};
  endfunction

  // Behavioural sha256_core: byte register file, START hashes the block, irq after a random delay
  logic [7:0] mem [128];
  int irq_cnt;
  assign core_data = mem[w_addr];

  initial begin
    logic [7:0]   blk [64];
    logic [255:0] dg;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    core_irq = 1'b0;
    irq_cnt  = 0;
    forever begin
      @(negedge clk);
      core_irq = 1'b0;
      if (!rst_n) begin
        irq_cnt = 0;
      end else begin
        if (irq_cnt > 0) begin
          irq_cnt--;
          if (irq_cnt == 0) core_irq = 1'b1;
        end
        if (we) begin
          if (w_addr == 7'd81 && data8 == 8'h01) begin
            for (int k = 0; k < 64; k++) blk[k] = mem[63 - k];
            dg = sha256_blk(blk);
            for (int j = 0; j < 32; j++) mem[117 - j] = dg[255 - 8*j -: 8];
            irq_cnt = int'($urandom_range(5, 40));
          end else begin
            mem[w_addr] = data8;
          end
        end
      end
    end
  end

  // Write monitor
  initial begin
    int  cyc;
    int  last_cyc;
    wr_t e;
    cyc = 0;
    last_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (we) begin
        if (m_valid) fail_now("write_during_read");
        if (wq.size() == 0) begin
          fail_now("unexpected_write");
        end else begin
          e = wq.pop_front();
          chk("wr_addr", 64'(w_addr), 64'(e.addr));
          chk("wr_data", 64'(data8), 64'(e.data));
          if (e.tag == 1) last_cyc = cyc;
          if (e.tag == 2) chk("start_latency", 64'(cyc - last_cyc), 64'(65 - e.len));
        end
      end
    end
  end

  // Digest monitor
  initial begin
    logic       held;
    logic [7:0] hd;
    logic [6:0] ha;
    dg_t        e;
    held = 1'b0;
    hd = '0;
    ha = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else if (m_valid) begin
        if (held) begin
          chk("hold_data", 64'(m_data), 64'(hd));
          chk("hold_addr", 64'(w_addr), 64'(ha));
        end
        if (m_ready) begin
          held = 1'b0;
          if (dq.size() == 0) begin
            fail_now("unexpected_digest");
          end else begin
            e = dq.pop_front();
            chk("dg_data", 64'(m_data), 64'(e.data));
            chk("dg_last", 64'(m_last), 64'(e.last));
            chk("dg_addr", 64'(w_addr), 64'(e.addr));
          end
        end else begin
          held = 1'b1;
          hd = m_data;
          ha = w_addr;
        end
      end else begin
        if (held) fail_now("valid_dropped");
        held = 1'b0;
      end
    end
  end

  // Sink ready driver: 0 random, 1 toggle, 2 always ready
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'($urandom_range(0, 1));
        1:       m_ready = ~m_ready;
        default: m_ready = 1'b1;
      endcase
    end
  end

  task automatic send_msg(input logic [7:0] msg[$], input bit gaps);
    for (int i = 0; i < msg.size(); i++) begin
      int  tmo;
      logic acc;
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_valid = 1'b1;
      s_data  = msg[i];
      s_last  = (i == msg.size() - 1);
      tmo = 0;
      acc = 1'b0;
      while (!acc && tmo < 300) begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk);
        #1;
        tmo++;
      end
      if (!acc) fail_now("accept_timeout");
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic expect_job(input logic [7:0] msg[$], input bit is_abc);
    logic [7:0]   blk [64];
    logic [63:0]  bits;
    logic [255:0] dg;
    int           len;
    len = msg.size();
    if (len > 55) begin
      for (int k = 0; k < 55; k++) wq.push_back('{7'(63 - k), msg[k], 0, len});
      return;
    end
    bits = 64'(len) * 64'd8;
    for (int k = 0; k < 64; k++) blk[k] = 8'h00;
    for (int k = 0; k < len; k++) blk[k] = msg[k];
    blk[len] = 8'h80;
    for (int i = 0; i < 8; i++) blk[56 + i] = bits[63 - 8*i -: 8];
    for (int k = 0; k < 64; k++) wq.push_back('{7'(63 - k), blk[k], (k == len - 1) ? 1 : 0, len});
    wq.push_back('{7'd81, 8'h01, 2, len});
    dg = is_abc ? ABC_DIGEST : sha256_blk(blk);
    for (int j = 0; j < 32; j++) dq.push_back('{dg[255 - 8*j -: 8], (j == 31), 7'(117 - j)});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((dq.size() > 0 || wq.size() > 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail_now("job_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [7:0] msg[$], input bit is_abc, input bit exp_err);
    expect_job(msg, is_abc);
    send_msg(msg, 1'b1);
    if (exp_err) begin
      chk("err_after_overflow", 64'(err), 64'd1);
      chk("busy_after_drain", 64'(busy), 64'd0);
      repeat (5) @(posedge clk);
      #1;
    end
    wait_idle();
    chk("err_flag", 64'(err), 64'(exp_err));
    chk("ready_idle", 64'(s_ready), 64'd1);
  endtask

  initial begin
    logic [7:0] msg[$];
    logic [7:0] abc[$];
    abc = '{8'h61, 8'h62, 8'h63};
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_w_addr", 64'(w_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 64'(s_ready), 64'd1);

    rdy_mode = 2;
    run_job(abc, 1'b1, 1'b0);

    rdy_mode = 0;
    msg = {};
    for (int i = 0; i < 55; i++) msg.push_back(8'h61);
    run_job(msg, 1'b0, 1'b0);

    msg = {};
    for (int i = 0; i < 56; i++) msg.push_back(8'($urandom));
    run_job(msg, 1'b0, 1'b1);

    msg = {};
    for (int i = 0; i < 60; i++) msg.push_back(8'($urandom));
    run_job(msg, 1'b0, 1'b1);

    rdy_mode = 1;
    run_job(abc, 1'b1, 1'b0);

    for (int n = 0; n < 6; n++) begin
      int len;
      rdy_mode = (n % 2 == 0) ? 0 : 1;
      len = (n == 0) ? 1 : int'($urandom_range(1, 55));
      msg = {};
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      run_job(msg, 1'b0, 1'b0);
    end

    // Reset while waiting for the core interrupt
    begin
      int n;
      rdy_mode = 2;
      expect_job(abc, 1'b1);
      send_msg(abc, 1'b0);
      n = 0;
      while (wq.size() > 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) fail_now("wait_reach_timeout");
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_wait_s_ready", 64'(s_ready), 64'd0);
      chk("rst_wait_m_valid", 64'(m_valid), 64'd0);
      chk("rst_wait_m_data", 64'(m_data), 64'd0);
      chk("rst_wait_m_last", 64'(m_last), 64'd0);
      chk("rst_wait_w_addr", 64'(w_addr), 64'd0);
      chk("rst_wait_data8", 64'(data8), 64'd0);
      chk("rst_wait_we", 64'(we), 64'd0);
      chk("rst_wait_busy", 64'(busy), 64'd0);
      chk("rst_wait_err", 64'(err), 64'd0);
      dq.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_job(abc, 1'b1, 1'b0);
    end

    repeat (20) @(posedge clk);
    #1;
    chk("wq_empty", 64'(wq.size()), 64'd0);
    chk("dq_empty", 64'(dq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
